pie_encoder: RTL

PIE_ENCODER -- requirements
Module: pie_encoder

---
 rtl/pie_encoder_pkg.sv | 31 +++
 rtl/pie_encoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pie_encoder_pkg.sv
// Shared definitions for the PIE (pulse-interval encoding) reader-to-tag
// encoder: state encoding, counter width and default segment timings.
package pie_encoder_pkg;

    // One down-counter times every segment; TRcal (1000 cycles) is the longest.
    localparam int unsigned CNT_W = 11;

    // Default timings in clk_10m cycles.
    localparam int unsigned TARI_CYC_DEF  = 125;
    localparam int unsigned PW_CYC_DEF    = 63;
    localparam int unsigned DELIM_CYC_DEF = 125;
    localparam int unsigned TRCAL_CYC_DEF = 1000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DELIM,
        ST_D0,
        ST_RTCAL,
        ST_TRCAL,
        ST_FETCH,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_DONE
    } state_e;

    // Counter load value for a segment lasting len cycles.
    function automatic logic [CNT_W-1:0] seg_ld(input int unsigned len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/pie_encoder.sv
// PIE encoder: emits delimiter, data-0, RTcal, optional TRcal and then the
// command bits as PIE symbols on rd_data (1 = carrier, 0 = attenuated).
module pie_encoder
    import pie_encoder_pkg::*;
#(
    parameter int unsigned TARI_CYC  = TARI_CYC_DEF,
    parameter int unsigned PW_CYC    = PW_CYC_DEF,
    parameter int unsigned DELIM_CYC = DELIM_CYC_DEF,
    parameter int unsigned TRCAL_CYC = TRCAL_CYC_DEF
) (
    input  logic clk_10m,
    input  logic rst_p,
    input  logic tx_start,
    input  logic tx_preamble,
    input  logic tx_bit_valid,
    input  logic tx_bit,
    input  logic tx_last,
    output logic tx_bit_ready,
    output logic rd_data,
    output logic tx_busy,
    output logic tx_done,
    output logic tx_err
);

    // Preamble symbols run as a whole symbol in one state: the counter is
    // loaded with L-1 and the line is high while count >= PW_CYC, which gives
    // L-PW_CYC high cycles followed by PW_CYC low cycles.
    localparam logic [CNT_W-1:0] DELIM_LD = seg_ld(DELIM_CYC);
    localparam logic [CNT_W-1:0] D0_LD    = seg_ld(TARI_CYC);
    localparam logic [CNT_W-1:0] RTCAL_LD = seg_ld(3 * TARI_CYC);
    localparam logic [CNT_W-1:0] TRCAL_LD = seg_ld(TRCAL_CYC);
    localparam logic [CNT_W-1:0] PW_TH    = CNT_W'(PW_CYC);
    // Data symbols: FETCH supplies the first high cycle, so BIT_HI covers the
    // remaining L-PW_CYC-1 high cycles and BIT_LO the PW_CYC low cycles.
    localparam logic [CNT_W-1:0] BIT0_LD  = seg_ld(TARI_CYC - PW_CYC - 1);
    localparam logic [CNT_W-1:0] BIT1_LD  = seg_ld(2 * TARI_CYC - PW_CYC - 1);
    localparam logic [CNT_W-1:0] PW_LD    = seg_ld(PW_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pre_q, pre_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    // State, segment counter and per-frame latches.
    always_ff @(posedge clk_10m) begin
        if (rst_p) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pre_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counter reload and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pre_d        = pre_q;
        last_d       = last_q;
        err_d        = err_q;
        rd_data      = 1'b1;
        tx_bit_ready = 1'b0;
        tx_busy      = 1'b1;
        tx_done      = 1'b0;
        tx_err       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_busy = 1'b0;
                if (tx_start) begin
                    state_d = ST_DELIM;
                    cnt_d   = DELIM_LD;
                    pre_d   = tx_preamble;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_DELIM: begin
                rd_data = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_D0;
                    cnt_d   = D0_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_D0: begin
                rd_data = (cnt_q >= PW_TH);
                if (cnt_q == '0) begin
                    state_d = ST_RTCAL;
                    cnt_d   = RTCAL_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RTCAL: begin
                rd_data = (cnt_q >= PW_TH);
                if (cnt_q == '0) begin
                    if (pre_q) begin
                        state_d = ST_TRCAL;
                        cnt_d   = TRCAL_LD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TRCAL: begin
                rd_data = (cnt_q >= PW_TH);
                if (cnt_q == '0) begin
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FETCH: begin
                tx_bit_ready = 1'b1;
                if (tx_bit_valid) begin
                    state_d = ST_BIT_HI;
                    cnt_d   = tx_bit ? BIT1_LD : BIT0_LD;
                    last_d  = tx_last;
                end else begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_BIT_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_BIT_LO;
                    cnt_d   = PW_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BIT_LO: begin
                rd_data = 1'b0;
                if (cnt_q == '0) begin
                    state_d = last_q ? ST_DONE : ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                tx_busy = 1'b0;
                tx_done = 1'b1;
                tx_err  = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
